pong_game_ctrl: RTL

Game-level sequencer for the pong ball datapath. Once per video frame it evaluates the current ball position against the walls and both paddles. It issues single-cycle touching_wall/touching_paddle pulses and then one ball_en update strobe, which the top level uses to clock-enable the ball position update. It also handles serve delay, miss detection, scoring and game-over.

---
 rtl/pong_pkg.sv | 30 +++
 rtl/pong_game_ctrl_if.sv | 34 +++
 rtl/pong_collide.sv | 85 ++++++++
 rtl/pong_game_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and default geometry for the pong game controller.
// State encoding is visible on state_o, so the enum values are fixed.
package pong_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SERVE     = 3'd1,
      ST_PLAY      = 3'd2,
      ST_SCORED    = 3'd3,
      ST_GAME_OVER = 3'd4
   } pong_state_t;

   // Position of a frame evaluation inside PLAY, counted from the sampled frame_tick.
   typedef enum logic [1:0] {
      PH_WAIT = 2'd0,
      PH_EVAL = 2'd1,
      PH_HIT  = 2'd2,
      PH_UPD  = 2'd3
   } play_phase_t;

   localparam int PONG_SCREEN_W  = 640;
   localparam int PONG_SCREEN_H  = 480;
   localparam int PONG_BALL_SIZE = 8;
   localparam int PONG_STEP      = 10;
   localparam int PONG_PADDLE_H  = 64;
   localparam int PONG_PADDLE_W  = 8;
   localparam int PONG_PADDLE_LX = 16;
   localparam int PONG_PADDLE_RX = 616;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Bundle of game-control signals between the video/ball datapath and the sequencer.
// The master side drives frame timing and positions; the slave side returns strobes and scores.
interface pong_game_ctrl_if #(
   parameter int X_W     = 10,
   parameter int Y_W     = 10,
   parameter int SCORE_W = 4
);
   logic               frame_tick;
   logic               start;
   logic [X_W-1:0]     ball_x;
   logic [Y_W-1:0]     ball_y;
   logic [Y_W-1:0]     paddle_l_y;
   logic [Y_W-1:0]     paddle_r_y;
   logic               ball_en;
   logic               touching_paddle;
   logic               touching_wall;
   logic               ball_reset;
   logic [SCORE_W-1:0] score_l;
   logic [SCORE_W-1:0] score_r;
   logic               game_over;
   logic [2:0]         state_o;

   modport master (
      output frame_tick, start, ball_x, ball_y, paddle_l_y, paddle_r_y,
      input  ball_en, touching_paddle, touching_wall, ball_reset,
             score_l, score_r, game_over, state_o
   );

   modport slave (
      input  frame_tick, start, ball_x, ball_y, paddle_l_y, paddle_r_y,
      output ball_en, touching_paddle, touching_wall, ball_reset,
             score_l, score_r, game_over, state_o
   );
endinterface

// File: rtl/pong_collide.sv
// Captures ball/paddle positions on capture and flags wall, paddle and miss conditions.
// Flags are combinational from the captured positions, valid the cycle after capture.
module pong_collide
   import pong_pkg::*;
#(
   parameter int X_W       = 10,
   parameter int Y_W       = 10,
   parameter int SCREEN_W  = PONG_SCREEN_W,
   parameter int SCREEN_H  = PONG_SCREEN_H,
   parameter int BALL_SIZE = PONG_BALL_SIZE,
   parameter int STEP      = PONG_STEP,
   parameter int PADDLE_H  = PONG_PADDLE_H,
   parameter int PADDLE_W  = PONG_PADDLE_W,
   parameter int PADDLE_LX = PONG_PADDLE_LX,
   parameter int PADDLE_RX = PONG_PADDLE_RX
)(
   input  logic           clk,
   input  logic           reset,
   input  logic           capture,
   input  logic [X_W-1:0] ball_x,
   input  logic [Y_W-1:0] ball_y,
   input  logic [Y_W-1:0] paddle_l_y,
   input  logic [Y_W-1:0] paddle_r_y,
   output logic           wall_hit,
   output logic           paddle_hit,
   output logic           miss_l,
   output logic           miss_r
);
   localparam logic [Y_W:0] WALL_LO   = (Y_W+1)'(STEP);
   localparam logic [Y_W:0] WALL_HI   = (Y_W+1)'(SCREEN_H - BALL_SIZE - STEP);
   localparam logic [Y_W:0] BALL_DY   = (Y_W+1)'(BALL_SIZE);
   localparam logic [Y_W:0] PAD_DY    = (Y_W+1)'(PADDLE_H);
   localparam logic [X_W:0] BALL_DX   = (X_W+1)'(BALL_SIZE);
   localparam logic [X_W:0] LPAD_L    = (X_W+1)'(PADDLE_LX);
   localparam logic [X_W:0] LPAD_R    = (X_W+1)'(PADDLE_LX + PADDLE_W);
   localparam logic [X_W:0] RPAD_L    = (X_W+1)'(PADDLE_RX);
   localparam logic [X_W:0] RPAD_R    = (X_W+1)'(PADDLE_RX + PADDLE_W);
   localparam logic [X_W:0] MISS_L_HI = (X_W+1)'(STEP);
   localparam logic [X_W:0] MISS_R_LO = (X_W+1)'(SCREEN_W - BALL_SIZE - STEP);
   localparam logic [X_W:0] SCR_W     = (X_W+1)'(SCREEN_W);

   logic [X_W-1:0] bx_q;
   logic [Y_W-1:0] by_q, pl_q, pr_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         bx_q <= '0;
         by_q <= '0;
         pl_q <= '0;
         pr_q <= '0;
      end else if (capture) begin
         bx_q <= ball_x;
         by_q <= ball_y;
         pl_q <= paddle_l_y;
         pr_q <= paddle_r_y;
      end
   end

   // One extra bit on every sum keeps the edge compares from aliasing near the top of range.
   logic [X_W:0] x0, x1;
   logic [Y_W:0] y0, y1, pl0, pl1, pr0, pr1;
   logic         hit_l, hit_r, raw_miss_l, raw_miss_r;

   assign x0  = {1'b0, bx_q};
   assign x1  = x0 + BALL_DX;
   assign y0  = {1'b0, by_q};
   assign y1  = y0 + BALL_DY;
   assign pl0 = {1'b0, pl_q};
   assign pl1 = pl0 + PAD_DY;
   assign pr0 = {1'b0, pr_q};
   assign pr1 = pr0 + PAD_DY;

   assign hit_l = (x0 < LPAD_R) && (x1 > LPAD_L) && (y1 > pl0) && (y0 < pl1);
   assign hit_r = (x1 > RPAD_L) && (x0 < RPAD_R) && (y1 > pr0) && (y0 < pr1);

   // Left miss includes positions that wrapped below zero.
   assign raw_miss_l = (x0 < MISS_L_HI) || (x0 >= SCR_W);
   assign raw_miss_r = (x0 >= MISS_R_LO) && (x0 < SCR_W);

   assign wall_hit   = (y0 < WALL_LO) || (y0 >= WALL_HI);
   assign paddle_hit = hit_l || hit_r;
   assign miss_l     = raw_miss_l && !paddle_hit;
   assign miss_r     = raw_miss_r && !paddle_hit;

endmodule

// File: rtl/pong_game_ctrl.sv
// Per-frame pong sequencer: serve delay, hit/miss evaluation, scoring and game-over.
// A PLAY frame_tick at T gives hit pulses at T+2 and ball_en (or SCORED) at T+3.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int X_W          = 10,
   parameter int Y_W          = 10,
   parameter int SCREEN_W     = PONG_SCREEN_W,
   parameter int SCREEN_H     = PONG_SCREEN_H,
   parameter int BALL_SIZE    = PONG_BALL_SIZE,
   parameter int STEP         = PONG_STEP,
   parameter int PADDLE_H     = PONG_PADDLE_H,
   parameter int PADDLE_W     = PONG_PADDLE_W,
   parameter int PADDLE_LX    = PONG_PADDLE_LX,
   parameter int PADDLE_RX    = PONG_PADDLE_RX,
   parameter int SERVE_FRAMES = 60,
   parameter int WIN_SCORE    = 7,
   parameter int SCORE_W      = 4
)(
   input  logic            clk,
   input  logic            reset,
   pong_game_ctrl_if.slave bus
);
   localparam int                 SC_W = $clog2(SERVE_FRAMES + 1);
   localparam logic [SCORE_W-1:0] WIN  = SCORE_W'(WIN_SCORE);

   pong_state_t        state_q, state_nxt;
   play_phase_t        ph_q, ph_nxt;
   logic [SC_W-1:0]    serve_cnt;
   logic               wall_cd, pad_cd, wall_q, pad_q, miss_l_q, miss_r_q;
   logic [SCORE_W-1:0] score_l_q, score_r_q, score_l_inc, score_r_inc;
   logic               capture, serve_done, scored_win;
   logic               wall_hit, paddle_hit, miss_l, miss_r;
   logic               ball_en, touching_wall, touching_paddle, ball_reset, game_over;

   pong_collide #(
      .X_W(X_W), .Y_W(Y_W), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H),
      .BALL_SIZE(BALL_SIZE), .STEP(STEP), .PADDLE_H(PADDLE_H), .PADDLE_W(PADDLE_W),
      .PADDLE_LX(PADDLE_LX), .PADDLE_RX(PADDLE_RX)
   ) u_collide (
      .clk        (clk),
      .reset      (reset),
      .capture    (capture),
      .ball_x     (bus.ball_x),
      .ball_y     (bus.ball_y),
      .paddle_l_y (bus.paddle_l_y),
      .paddle_r_y (bus.paddle_r_y),
      .wall_hit   (wall_hit),
      .paddle_hit (paddle_hit),
      .miss_l     (miss_l),
      .miss_r     (miss_r)
   );

   assign capture     = (state_q == ST_PLAY) && (ph_q == PH_WAIT) && bus.frame_tick;
   assign serve_done  = bus.frame_tick && (serve_cnt == SC_W'(SERVE_FRAMES - 1));
   assign score_l_inc = (score_l_q >= WIN) ? WIN : score_l_q + SCORE_W'(1);
   assign score_r_inc = (score_r_q >= WIN) ? WIN : score_r_q + SCORE_W'(1);
   assign scored_win  = miss_l_q ? (score_r_inc == WIN) : (score_l_inc == WIN);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ph_q    <= PH_WAIT;
      end else begin
         state_q <= state_nxt;
         ph_q    <= ph_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      ph_nxt    = PH_WAIT;
      case (state_q)
         ST_IDLE, ST_GAME_OVER: if (bus.start) state_nxt = ST_SERVE;
         ST_SERVE:              if (serve_done) state_nxt = ST_PLAY;
         ST_PLAY: begin
            case (ph_q)
               PH_WAIT: if (capture) ph_nxt = PH_EVAL;
               PH_EVAL: ph_nxt = PH_HIT;
               PH_HIT: begin
                  if (miss_l_q || miss_r_q) state_nxt = ST_SCORED;
                  else                      ph_nxt    = PH_UPD;
               end
               default: ph_nxt = PH_WAIT;
            endcase
         end
         ST_SCORED: state_nxt = scored_win ? ST_GAME_OVER : ST_SERVE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      ball_reset      = (state_q != ST_PLAY);
      game_over       = (state_q == ST_GAME_OVER);
      touching_wall   = (state_q == ST_PLAY) && (ph_q == PH_HIT) && wall_q;
      touching_paddle = (state_q == ST_PLAY) && (ph_q == PH_HIT) && pad_q;
      ball_en         = (state_q == ST_PLAY) && (ph_q == PH_UPD);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         serve_cnt <= '0;
         wall_cd   <= 1'b0;
         pad_cd    <= 1'b0;
         wall_q    <= 1'b0;
         pad_q     <= 1'b0;
         miss_l_q  <= 1'b0;
         miss_r_q  <= 1'b0;
         score_l_q <= '0;
         score_r_q <= '0;
      end else begin
         if (state_q != ST_SERVE)  serve_cnt <= '0;
         else if (bus.frame_tick) serve_cnt <= serve_done ? '0 : serve_cnt + SC_W'(1);

         // A hit issued this frame blocks the same kind of hit on the next frame.
         if (state_q != ST_PLAY) begin
            wall_cd <= 1'b0;
            pad_cd  <= 1'b0;
         end else if (ph_q == PH_EVAL) begin
            wall_q   <= wall_hit && !wall_cd;
            wall_cd  <= wall_hit && !wall_cd;
            pad_q    <= paddle_hit && !pad_cd;
            pad_cd   <= paddle_hit && !pad_cd;
            miss_l_q <= miss_l;
            miss_r_q <= miss_r;
         end

         if ((state_q == ST_IDLE || state_q == ST_GAME_OVER) && bus.start) begin
            score_l_q <= '0;
            score_r_q <= '0;
         end else if (state_q == ST_SCORED) begin
            if (miss_l_q) score_r_q <= score_r_inc;
            else          score_l_q <= score_l_inc;
         end
      end
   end

   assign bus.ball_en         = ball_en;
   assign bus.touching_wall   = touching_wall;
   assign bus.touching_paddle = touching_paddle;
   assign bus.ball_reset      = ball_reset;
   assign bus.game_over       = game_over;
   assign bus.score_l         = score_l_q;
   assign bus.score_r         = score_r_q;
   assign bus.state_o         = state_q;

endmodule
